mmu_io_datapath: RTL and testbench

- Bundles the data paths on both sides of the 2x2 systolic MMU.
- Input side: a two-column weight FIFO that feeds the MMU column inputs during weight load, with column 1 skewed one cycle later.
- Output side: a two-bank accumulator that absorbs the skewed MMU column sums, then a two-column activation pipeline (ReLU, affine normalisation, int8 quantisation) producing packed 16-bit data to refill the unified buffer.

---
 rtl/mmu_io_datapath.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mmu_io_datapath.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_io_datapath.sv
// mmu_io_datapath
//   Data paths on both sides of the 2x2 systolic MMU.
//   Input side : two-column weight FIFO; column 1 is presented one cycle
//                after column 0 to match the array skew.
//   Output side: two-bank accumulator that realigns the skewed column sums,
//                followed by a per-column ReLU -> affine norm -> int8 quant
//                pipeline whose packed result refills the unified buffer.
//
// Parameters
//   FIFO_DEPTH : entries per weight column (power of two)
//   ACC_W      : accumulator / normalisation width
//
// Ports
//   clk, reset                 : clock, synchronous active-high clear of all state
//   wf_reset                   : synchronous clear of the weight FIFO only
//   wf_push_col0/1, wf_data_in : push a weight byte into column 0 / 1
//   wf_pop                     : pop both columns
//   wf_col0_out, wf_col1_out   : registered weights (col1 one cycle later)
//   wf_col1_raw                : combinational head of column 1 (0 if empty)
//   mmu_valid, acc_enable,
//   acc_addr_sel, mmu_col0/1_in: MMU sums and accumulate controls
//   acc0, acc1, acc_valid      : accumulator results
//   norm_gain/bias/shift       : affine normalisation
//   q_inv_scale, q_zero_point  : int8 quantisation
//   target0, target1           : loss targets
//   ap_valid, ap_col0/1,
//   ap_packed                  : activation results, packed {col1, col0}
//   loss_valid, loss0, loss1   : squared-error loss
//
// Optional feature: define MMU_IO_LOSS_EN to build the loss unit; otherwise
// the loss outputs are tied to zero.

module mmu_io_datapath #(
   parameter int FIFO_DEPTH = 4,
   parameter int ACC_W      = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wf_reset,
   input  logic                    wf_push_col0,
   input  logic                    wf_push_col1,
   input  logic [7:0]              wf_data_in,
   input  logic                    wf_pop,
   output logic [7:0]              wf_col0_out,
   output logic [7:0]              wf_col1_out,
   output logic [7:0]              wf_col1_raw,
   input  logic                    mmu_valid,
   input  logic                    acc_enable,
   input  logic                    acc_addr_sel,
   input  logic signed [15:0]      mmu_col0_in,
   input  logic signed [15:0]      mmu_col1_in,
   output logic signed [ACC_W-1:0] acc0,
   output logic signed [ACC_W-1:0] acc1,
   output logic                    acc_valid,
   input  logic signed [15:0]      norm_gain,
   input  logic signed [ACC_W-1:0] norm_bias,
   input  logic [4:0]              norm_shift,
   input  logic signed [15:0]      q_inv_scale,
   input  logic signed [7:0]       q_zero_point,
   input  logic signed [ACC_W-1:0] target0,
   input  logic signed [ACC_W-1:0] target1,
   output logic                    ap_valid,
   output logic signed [7:0]       ap_col0,
   output logic signed [7:0]       ap_col1,
   output logic [15:0]             ap_packed,
   output logic                    loss_valid,
   output logic [ACC_W-1:0]        loss0,
   output logic [ACC_W-1:0]        loss1
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PROD_W = ACC_W + 16;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Weight FIFO
   // ------------------------------------------------------------------
   logic [7:0]       mem0 [FIFO_DEPTH];
   logic [7:0]       mem1 [FIFO_DEPTH];
   logic [PTR_W-1:0] rd0, wr0, rd1, wr1;
   logic [PTR_W:0]   cnt0, cnt1;
   logic [7:0]       stage1;
   logic [7:0]       head0, head1;
   logic             push_ok0, push_ok1, pop_ok0, pop_ok1;

   always_comb begin
      push_ok0 = wf_push_col0 && (cnt0 != DEPTH_C);
      push_ok1 = wf_push_col1 && (cnt1 != DEPTH_C);
      pop_ok0  = wf_pop && (cnt0 != '0);
      pop_ok1  = wf_pop && (cnt1 != '0);
      head0    = (cnt0 != '0) ? mem0[rd0] : '0;
      head1    = (cnt1 != '0) ? mem1[rd1] : '0;
   end

   assign wf_col1_raw = head1;

   always_ff @(posedge clk) begin
      if (reset || wf_reset) begin
         rd0         <= '0;
         wr0         <= '0;
         cnt0        <= '0;
         rd1         <= '0;
         wr1         <= '0;
         cnt1        <= '0;
         wf_col0_out <= '0;
         stage1      <= '0;
         wf_col1_out <= '0;
      end else begin
         if (push_ok0) begin
            mem0[wr0] <= wf_data_in;
            wr0       <= wr0 + PTR_W'(1);
         end
         if (push_ok1) begin
            mem1[wr1] <= wf_data_in;
            wr1       <= wr1 + PTR_W'(1);
         end
         if (pop_ok0) rd0 <= rd0 + PTR_W'(1);
         if (pop_ok1) rd1 <= rd1 + PTR_W'(1);
         cnt0 <= cnt0 + (PTR_W+1)'(push_ok0) - (PTR_W+1)'(pop_ok0);
         cnt1 <= cnt1 + (PTR_W+1)'(push_ok1) - (PTR_W+1)'(pop_ok1);
         // pop reads the pre-push head, so push+pop never bypasses
         if (wf_pop) begin
            wf_col0_out <= head0;
            stage1      <= head1;
         end
         wf_col1_out <= stage1;
      end
   end

   // ------------------------------------------------------------------
   // Accumulator: column 0 is delayed one cycle to line up with column 1
   // ------------------------------------------------------------------
   logic signed [15:0]      col0_d;
   logic                    valid_d, en_d, addr_d;
   logic signed [ACC_W-1:0] bank0 [2];
   logic signed [ACC_W-1:0] bank1 [2];
   logic signed [ACC_W-1:0] sum0, sum1;

   always_comb begin
      sum0 = ACC_W'(col0_d)      + (en_d ? bank0[addr_d] : '0);
      sum1 = ACC_W'(mmu_col1_in) + (en_d ? bank1[addr_d] : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col0_d    <= '0;
         valid_d   <= 1'b0;
         en_d      <= 1'b0;
         addr_d    <= 1'b0;
         acc0      <= '0;
         acc1      <= '0;
         acc_valid <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else begin
         col0_d  <= mmu_col0_in;
         valid_d <= mmu_valid;
         en_d    <= acc_enable;
         addr_d  <= acc_addr_sel;
         if (valid_d) begin
            bank0[addr_d] <= sum0;
            bank1[addr_d] <= sum1;
            acc0          <= sum0;
            acc1          <= sum1;
            acc_valid     <= 1'b1;
         end else begin
            acc_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Activation pipeline
   // ------------------------------------------------------------------
   function automatic logic signed [ACC_W-1:0] norm_f(
      input logic signed [ACC_W-1:0] r,
      input logic signed [15:0]      gain,
      input logic signed [ACC_W-1:0] bias,
      input logic [4:0]              shift
   );
      logic signed [PROD_W-1:0] prod;
      logic signed [PROD_W-1:0] sh;
      logic signed [PROD_W:0]   sum;
      prod = PROD_W'(r) * PROD_W'(gain);
      sh   = prod >>> shift;
      sum  = (PROD_W+1)'(sh) + (PROD_W+1)'(bias);
      // in range when every bit above the result sign matches it
      if (sum[PROD_W:ACC_W-1] == '0 || sum[PROD_W:ACC_W-1] == '1)
         return sum[ACC_W-1:0];
      else if (sum[PROD_W])
         return {1'b1, {(ACC_W-1){1'b0}}};
      else
         return {1'b0, {(ACC_W-1){1'b1}}};
   endfunction

   localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(128);

   function automatic logic signed [7:0] quant_f(
      input logic signed [ACC_W-1:0] n,
      input logic [15:0]             inv,
      input logic signed [7:0]       zp
   );
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W:0]    q;
      // Q0.16 scale has no integer bit: zero-extend so 0x8000 means 0.5
      prod = PROD_W'(n) * $signed({{(PROD_W-16){1'b0}}, inv});
      q    = (ACC_W+1)'(prod >>> 16) + (ACC_W+1)'(zp);
      if (q > Q_MAX)
         return 8'h7F;
      else if (q < Q_MIN)
         return 8'h80;
      else
         return q[7:0];
   endfunction

   logic signed [ACC_W-1:0] s1_r0, s1_r1, s2_n0, s2_n1;
   logic                    s1_v, s2_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_r0    <= '0;
         s1_r1    <= '0;
         s1_v     <= 1'b0;
         s2_n0    <= '0;
         s2_n1    <= '0;
         s2_v     <= 1'b0;
         ap_col0  <= '0;
         ap_col1  <= '0;
         ap_valid <= 1'b0;
      end else begin
         s1_r0    <= acc0[ACC_W-1] ? '0 : acc0;
         s1_r1    <= acc1[ACC_W-1] ? '0 : acc1;
         s1_v     <= acc_valid;
         s2_n0    <= norm_f(s1_r0, norm_gain, norm_bias, norm_shift);
         s2_n1    <= norm_f(s1_r1, norm_gain, norm_bias, norm_shift);
         s2_v     <= s1_v;
         ap_col0  <= quant_f(s2_n0, q_inv_scale, q_zero_point);
         ap_col1  <= quant_f(s2_n1, q_inv_scale, q_zero_point);
         ap_valid <= s2_v;
      end
   end

   assign ap_packed = {ap_col1, ap_col0};

   // ------------------------------------------------------------------
   // Squared-error loss
   // ------------------------------------------------------------------
`ifdef MMU_IO_LOSS_EN
   localparam int SQ_W = 2 * ACC_W + 2;

   function automatic logic [ACC_W-1:0] loss_f(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] t
   );
      logic signed [ACC_W:0]  d;
      logic signed [SQ_W-1:0] sq;
      d  = (ACC_W+1)'(a) - (ACC_W+1)'(t);
      sq = SQ_W'(d) * SQ_W'(d);
      if (sq[SQ_W-1:ACC_W-1] != '0)
         return {1'b0, {(ACC_W-1){1'b1}}};
      else
         return sq[ACC_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         loss_valid <= 1'b0;
         loss0      <= '0;
         loss1      <= '0;
      end else begin
         loss_valid <= acc_valid;
         if (acc_valid) begin
            loss0 <= loss_f(acc0, target0);
            loss1 <= loss_f(acc1, target1);
         end
      end
   end
`else
   logic unused_targets;
   assign unused_targets = ^{target0, target1};
   assign loss_valid     = 1'b0;
   assign loss0          = '0;
   assign loss1          = '0;
`endif

endmodule

// File: tb/tb_mmu_io_datapath.sv
// tb_mmu_io_datapath
//   Directed-vector bench for mmu_io_datapath: weight FIFO skew, full and
//   reset handling, accumulator overwrite/accumulate/bank isolation and
//   latency, activation pipeline values and latency, reset mid-flight,
//   and the loss unit when MMU_IO_LOSS_EN is defined.

module tb_mmu_io_datapath;

   logic        clk;
   logic        reset;
   logic        wf_reset;
   logic        wf_push_col0;
   logic        wf_push_col1;
   logic [7:0]  wf_data_in;
   logic        wf_pop;
   logic [7:0]  wf_col0_out;
   logic [7:0]  wf_col1_out;
   logic [7:0]  wf_col1_raw;
   logic        mmu_valid;
   logic        acc_enable;
   logic        acc_addr_sel;
   logic [15:0] mmu_col0_in;
   logic [15:0] mmu_col1_in;
   logic [31:0] acc0;
   logic [31:0] acc1;
   logic        acc_valid;
   logic [15:0] norm_gain;
   logic [31:0] norm_bias;
   logic [4:0]  norm_shift;
   logic [15:0] q_inv_scale;
   logic [7:0]  q_zero_point;
   logic [31:0] target0;
   logic [31:0] target1;
   logic        ap_valid;
   logic [7:0]  ap_col0;
   logic [7:0]  ap_col1;
   logic [15:0] ap_packed;
   logic        loss_valid;
   logic [31:0] loss0;
   logic [31:0] loss1;

   int total = 0;
   int bad   = 0;

   mmu_io_datapath #(
      .FIFO_DEPTH(4),
      .ACC_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wf_reset(wf_reset),
      .wf_push_col0(wf_push_col0),
      .wf_push_col1(wf_push_col1),
      .wf_data_in(wf_data_in),
      .wf_pop(wf_pop),
      .wf_col0_out(wf_col0_out),
      .wf_col1_out(wf_col1_out),
      .wf_col1_raw(wf_col1_raw),
      .mmu_valid(mmu_valid),
      .acc_enable(acc_enable),
      .acc_addr_sel(acc_addr_sel),
      .mmu_col0_in(mmu_col0_in),
      .mmu_col1_in(mmu_col1_in),
      .acc0(acc0),
      .acc1(acc1),
      .acc_valid(acc_valid),
      .norm_gain(norm_gain),
      .norm_bias(norm_bias),
      .norm_shift(norm_shift),
      .q_inv_scale(q_inv_scale),
      .q_zero_point(q_zero_point),
      .target0(target0),
      .target1(target1),
      .ap_valid(ap_valid),
      .ap_col0(ap_col0),
      .ap_col1(ap_col1),
      .ap_packed(ap_packed),
      .loss_valid(loss_valid),
      .loss0(loss0),
      .loss1(loss1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // one active edge, then settle so outputs are sampled away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one MMU result: column 0 now, column 1 one cycle later
   task automatic acc_op(input logic addr, input logic en,
                         input logic [15:0] c0, input logic [15:0] c1);
      mmu_valid    = 1'b1;
      acc_addr_sel = addr;
      acc_enable   = en;
      mmu_col0_in  = c0;
      mmu_col1_in  = '0;
      tick();
      mmu_valid   = 1'b0;
      acc_enable  = 1'b0;
      mmu_col0_in = '0;
      mmu_col1_in = c1;
      tick();
      mmu_col1_in = '0;
   endtask

   initial begin
      reset        = 1'b1;
      wf_reset     = 1'b0;
      wf_push_col0 = 1'b0;
      wf_push_col1 = 1'b0;
      wf_data_in   = '0;
      wf_pop       = 1'b0;
      mmu_valid    = 1'b0;
      acc_enable   = 1'b0;
      acc_addr_sel = 1'b0;
      mmu_col0_in  = '0;
      mmu_col1_in  = '0;
      norm_gain    = 16'd1;
      norm_bias    = '0;
      norm_shift   = '0;
      q_inv_scale  = 16'h8000;
      q_zero_point = '0;
      target0      = '0;
      target1      = '0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_col0", {24'b0, wf_col0_out}, 32'h0);
      chk("rst_col1", {24'b0, wf_col1_out}, 32'h0);
      chk("rst_raw", {24'b0, wf_col1_raw}, 32'h0);
      chk("rst_acc0", acc0, 32'h0);
      chk("rst_accv", {31'b0, acc_valid}, 32'h0);
      chk("rst_apv", {31'b0, ap_valid}, 32'h0);
      chk("rst_packed", {16'b0, ap_packed}, 32'h0);

      // FIFO skew
      wf_push_col0 = 1'b1; wf_data_in = 8'd1; tick();
      wf_data_in = 8'd2; tick();
      wf_push_col0 = 1'b0; wf_push_col1 = 1'b1; wf_data_in = 8'd3; tick();
      wf_data_in = 8'd4; tick();
      wf_push_col1 = 1'b0;
      chk("raw_head", {24'b0, wf_col1_raw}, 32'd3);
      wf_pop = 1'b1; tick();
      chk("skew_c0_a", {24'b0, wf_col0_out}, 32'd1);
      chk("skew_c1_a", {24'b0, wf_col1_out}, 32'd0);
      tick();
      chk("skew_c0_b", {24'b0, wf_col0_out}, 32'd2);
      chk("skew_c1_b", {24'b0, wf_col1_out}, 32'd3);
      wf_pop = 1'b0; tick();
      chk("hold_c0", {24'b0, wf_col0_out}, 32'd2);
      chk("skew_c1_c", {24'b0, wf_col1_out}, 32'd4);
      chk("raw_empty", {24'b0, wf_col1_raw}, 32'd0);
      wf_pop = 1'b1; tick();
      chk("empty_c0", {24'b0, wf_col0_out}, 32'd0);
      wf_pop = 1'b0; tick();
      chk("empty_c1", {24'b0, wf_col1_out}, 32'd0);

      // FIFO full: fifth push dropped
      wf_push_col0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wf_data_in = 8'(10 + i);
         tick();
      end
      wf_push_col0 = 1'b0;
      wf_pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("full_pop", {24'b0, wf_col0_out}, 32'(10 + i));
      end
      tick();
      chk("full_drop", {24'b0, wf_col0_out}, 32'd0);

      // push+pop on an empty column: pop sees empty, data stays queued
      wf_push_col0 = 1'b1; wf_data_in = 8'd7; tick();
      chk("pp_nobypass", {24'b0, wf_col0_out}, 32'd0);
      wf_push_col0 = 1'b0; tick();
      chk("pp_later", {24'b0, wf_col0_out}, 32'd7);
      wf_pop = 1'b0;

      // wf_reset empties the FIFO and zeroes outputs
      wf_push_col0 = 1'b1; wf_data_in = 8'd55; tick();
      wf_push_col0 = 1'b0; wf_reset = 1'b1; tick();
      wf_reset = 1'b0;
      chk("wfr_out", {24'b0, wf_col0_out}, 32'd0);
      wf_pop = 1'b1; tick();
      wf_pop = 1'b0;
      chk("wfr_empty", {24'b0, wf_col0_out}, 32'd0);

      // accumulate with latency check
      mmu_valid = 1'b1; acc_enable = 1'b0; acc_addr_sel = 1'b0;
      mmu_col0_in = 16'h0010; tick();
      mmu_valid = 1'b0; mmu_col0_in = '0; mmu_col1_in = 16'hFFFF;
      chk("lat_t1", {31'b0, acc_valid}, 32'd0);
      tick();
      mmu_col1_in = '0;
      chk("lat_t2", {31'b0, acc_valid}, 32'd1);
      chk("ovw_acc0", acc0, 32'd16);
      chk("ovw_acc1", acc1, 32'hFFFFFFFF);
      tick();
      chk("accv_drop", {31'b0, acc_valid}, 32'd0);
      chk("acc0_hold", acc0, 32'd16);
      acc_op(1'b0, 1'b1, 16'h0010, 16'hFFFF);
      chk("add_acc0", acc0, 32'd32);
      chk("add_acc1", acc1, 32'hFFFFFFFE);

      // bank isolation
      acc_op(1'b1, 1'b0, 16'd100, 16'd100);
      chk("b1_acc0", acc0, 32'd100);
      acc_op(1'b0, 1'b1, 16'd1, 16'd1);
      chk("b0_acc0", acc0, 32'd33);
      chk("b0_acc1", acc1, 32'hFFFFFFFF);
      acc_op(1'b1, 1'b1, 16'd0, 16'd0);
      chk("b1_keep0", acc0, 32'd100);
      chk("b1_keep1", acc1, 32'd100);
      tick(); tick(); tick(); tick();

      // activation: back-to-back results, gain 1, scale 0.5
      mmu_valid = 1'b1; acc_enable = 1'b0; acc_addr_sel = 1'b0;
      mmu_col0_in = 16'd20; tick();
      mmu_col0_in = 16'd1000; mmu_col1_in = 16'hFFFB; tick();
      mmu_valid = 1'b0; mmu_col0_in = '0; mmu_col1_in = 16'd7; tick();
      mmu_col1_in = '0; tick();
      chk("ap_lat", {31'b0, ap_valid}, 32'd0);
      tick();
      chk("ap_v1", {31'b0, ap_valid}, 32'd1);
      chk("ap_c0", {24'b0, ap_col0}, 32'd10);
      chk("ap_c1_relu", {24'b0, ap_col1}, 32'd0);
      chk("ap_pk1", {16'b0, ap_packed}, 32'h000A);
      tick();
      chk("ap_v2", {31'b0, ap_valid}, 32'd1);
      chk("ap_pk2", {16'b0, ap_packed}, 32'h037F);
      tick();
      chk("ap_v_end", {31'b0, ap_valid}, 32'd0);

      // shift, negative bias, floor, zero point
      norm_gain = 16'd3; norm_shift = 5'd1; norm_bias = 32'hFFFFFFFD;
      q_zero_point = 8'd5;
      acc_op(1'b0, 1'b0, 16'd20, 16'hFFFA);
      tick(); tick(); tick();
      chk("ap_aff_v", {31'b0, ap_valid}, 32'd1);
      chk("ap_aff", {16'b0, ap_packed}, 32'h0312);

      // large negative result clamps to -128
      norm_gain = 16'd1; norm_shift = '0; norm_bias = 32'hFFFFFC18;
      q_zero_point = '0;
      acc_op(1'b0, 1'b0, 16'd0, 16'd0);
      tick(); tick(); tick();
      chk("ap_neg_sat", {24'b0, ap_col0}, 32'h80);

`ifdef MMU_IO_LOSS_EN
      target0 = 32'd3; target1 = 32'd2;
      acc_op(1'b0, 1'b0, 16'd7, 16'hFFFD);
      tick();
      chk("loss_v", {31'b0, loss_valid}, 32'd1);
      chk("loss0", loss0, 32'd16);
      chk("loss1", loss1, 32'd25);
      target0 = 32'h80000000;
      acc_op(1'b0, 1'b0, 16'd7, 16'd2);
      tick();
      chk("loss0_sat", loss0, 32'h7FFFFFFF);
      chk("loss1_zero", loss1, 32'd0);
`else
      acc_op(1'b0, 1'b0, 16'd7, 16'd2);
      tick();
      chk("loss_v_off", {31'b0, loss_valid}, 32'd0);
      chk("loss0_off", loss0, 32'd0);
`endif
      tick(); tick(); tick();

      // reset in mid-flight kills queued valids
      acc_op(1'b0, 1'b0, 16'd40, 16'd40);
      tick();
      reset = 1'b1; tick();
      reset = 1'b0;
      chk("mr_acc0", acc0, 32'd0);
      chk("mr_apv0", {31'b0, ap_valid}, 32'd0);
      tick();
      chk("mr_apv1", {31'b0, ap_valid}, 32'd0);
      tick();
      chk("mr_apv2", {31'b0, ap_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
